// File: rtl/led_scan_mux_if.sv
// Front-panel LED scan bus: panel data/enables toward the scanner, LED drive lines back out.
// The driver side (master) owns the inputs; the scanner (slave) owns the outputs.
interface led_scan_mux_if #(
   parameter int NUM_BANKS  = 6,
   parameter int NUM_DIGITS = 2
);
   logic [8*NUM_BANKS-1:0]  iBankData;
   logic [NUM_BANKS-1:0]    iBankEn;
   logic [NUM_BANKS-1:0]    iBlinkMask;
   logic [5*NUM_DIGITS-1:0] iDigitVal;
   logic [NUM_DIGITS-1:0]   iDigitDp;
   logic [NUM_DIGITS-1:0]   iDigitEn;
   logic [7:0]              oLedData;
   logic [NUM_BANKS-1:0]    oBankSel;
   logic [NUM_DIGITS-1:0]   oDigitSel_N;
   logic                    oFrameStart;

   modport master (
      output iBankData, iBankEn, iBlinkMask, iDigitVal, iDigitDp, iDigitEn,
      input  oLedData, oBankSel, oDigitSel_N, oFrameStart
   );

   modport slave (
      input  iBankData, iBankEn, iBlinkMask, iDigitVal, iDigitDp, iDigitEn,
      output oLedData, oBankSel, oDigitSel_N, oFrameStart
   );
endinterface

// File: rtl/led_scan_mux.sv
// Time-multiplexed scan of LED banks and 7-segment digits (each digit followed by a blanking slot).
// Outputs registered, one cycle behind inputs; no backpressure, disabled slots are skipped.
module led_scan_mux #(
   parameter int NUM_BANKS    = 6,
   parameter int NUM_DIGITS   = 2,
   parameter int DWELL_CLKS   = 3666,
   parameter int BLINK_FRAMES = 32
) (
   input logic           iClk,
   input logic           iRst_n,
   led_scan_mux_if.slave bus
);
   localparam int NPOS  = NUM_BANKS + 2 * NUM_DIGITS;
   localparam int POS_W = $clog2(NPOS);
   localparam int DW_W  = $clog2(DWELL_CLKS);
   localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic {ST_SEARCH, ST_SCAN} state_t;

   state_t              state_q;
   logic [POS_W-1:0]    pos_q;
   logic [DW_W-1:0]     dwell_q;
   logic [BF_W-1:0]     blink_cnt_q;
   logic                blink_ph_q, blink_ph_d;
   logic [7:0]          led_q, led_d;
   logic [NUM_BANKS-1:0]  bank_sel_q, bank_sel_d;
   logic [NUM_DIGITS-1:0] digit_sel_n_q, digit_sel_n_d;
   logic                frame_q;

   logic [NPOS-1:0]     pos_en;
   logic                any_en, tc, nxt_found, boundary, tgt_act;
   logic [POS_W-1:0]    first_pos, nxt_pos, tgt_pos;

   function automatic logic [6:0] seg7(input logic [4:0] code);
      case (code)
         5'd0:  seg7 = 7'h40;
         5'd1:  seg7 = 7'h79;
         5'd2:  seg7 = 7'h24;
         5'd3:  seg7 = 7'h30;
         5'd4:  seg7 = 7'h19;
         5'd5:  seg7 = 7'h12;
         5'd6:  seg7 = 7'h02;
         5'd7:  seg7 = 7'h78;
         5'd8:  seg7 = 7'h00;
         5'd9:  seg7 = 7'h10;
         5'd10: seg7 = 7'h08;
         5'd11: seg7 = 7'h03;
         5'd12: seg7 = 7'h46;
         5'd13: seg7 = 7'h21;
         5'd14: seg7 = 7'h06;
         5'd15: seg7 = 7'h0E;
         5'd16: seg7 = 7'h3F;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   // A digit's blanking slot follows the digit's own enable.
   always_comb begin
      pos_en = '0;
      for (int b = 0; b < NUM_BANKS; b++) pos_en[b] = bus.iBankEn[b];
      for (int d = 0; d < NUM_DIGITS; d++) begin
         pos_en[NUM_BANKS+2*d]   = bus.iDigitEn[d];
         pos_en[NUM_BANKS+2*d+1] = bus.iDigitEn[d];
      end
   end

   assign any_en = |pos_en;
   assign tc     = (dwell_q == DW_W'(DWELL_CLKS - 1));

   // No enabled position strictly after the current one means the scan wraps.
   always_comb begin
      first_pos = '0;
      nxt_pos   = '0;
      nxt_found = 1'b0;
      for (int p = NPOS - 1; p >= 0; p--) begin
         if (pos_en[p]) first_pos = POS_W'(p);
         if (pos_en[p] && p > int'(pos_q)) begin
            nxt_pos   = POS_W'(p);
            nxt_found = 1'b1;
         end
      end
      if (!nxt_found) nxt_pos = first_pos;
   end

   assign boundary   = (state_q == ST_SCAN) && tc && any_en && !nxt_found;
   assign blink_ph_d = blink_ph_q ^ (boundary && blink_cnt_q == BF_W'(BLINK_FRAMES - 1));

   always_comb begin
      tgt_act = 1'b1;
      tgt_pos = pos_q;
      if (state_q == ST_SEARCH) begin
         tgt_act = any_en;
         tgt_pos = first_pos;
      end else if (tc) begin
         tgt_act = any_en;
         tgt_pos = nxt_pos;
      end
   end

   // Outputs are decoded for the slot that will be current after this edge.
   always_comb begin
      led_d         = 8'h00;
      bank_sel_d    = '0;
      digit_sel_n_d = '1;
      if (tgt_act) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(tgt_pos) == b) begin
               bank_sel_d[b] = bus.iBankEn[b];
               led_d = (bus.iBlinkMask[b] && blink_ph_d) ? 8'h00 : bus.iBankData[8*b +: 8];
            end
         end
         for (int d = 0; d < NUM_DIGITS; d++) begin
            if (int'(tgt_pos) == NUM_BANKS + 2 * d) begin
               digit_sel_n_d[d] = ~bus.iDigitEn[d];
               led_d = {~bus.iDigitDp[d], seg7(bus.iDigitVal[5*d +: 5])};
            end else if (int'(tgt_pos) == NUM_BANKS + 2 * d + 1) begin
               led_d = 8'hFF;
            end
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q       <= ST_SEARCH;
         pos_q         <= '0;
         dwell_q       <= '0;
         blink_cnt_q   <= '0;
         blink_ph_q    <= 1'b0;
         led_q         <= 8'h00;
         bank_sel_q    <= '0;
         digit_sel_n_q <= '1;
         frame_q       <= 1'b0;
      end else begin
         frame_q       <= 1'b0;
         led_q         <= led_d;
         bank_sel_q    <= bank_sel_d;
         digit_sel_n_q <= digit_sel_n_d;
         blink_ph_q    <= blink_ph_d;
         case (state_q)
            ST_SEARCH: begin
               if (any_en) begin
                  state_q <= ST_SCAN;
                  pos_q   <= first_pos;
                  dwell_q <= '0;
                  frame_q <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (!tc) begin
                  dwell_q <= dwell_q + DW_W'(1);
               end else begin
                  dwell_q <= '0;
                  if (!any_en) begin
                     state_q <= ST_SEARCH;
                  end else begin
                     pos_q <= nxt_pos;
                     if (boundary) begin
                        frame_q <= 1'b1;
                        if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) blink_cnt_q <= '0;
                        else blink_cnt_q <= blink_cnt_q + BF_W'(1);
                     end
                  end
               end
            end
            default: state_q <= ST_SEARCH;
         endcase
      end
   end

   assign bus.oLedData    = led_q;
   assign bus.oBankSel    = bank_sel_q;
   assign bus.oDigitSel_N = digit_sel_n_q;
   assign bus.oFrameStart = frame_q;
endmodule

// File: tb/tb_led_scan_mux.sv
// Bench for led_scan_mux: directed scenarios plus a randomized run, all checked against a slot-level reference model.
module tb_led_scan_mux;
   localparam int NB   = 6;
   localparam int ND   = 2;
   localparam int DW   = 4;
   localparam int BF   = 2;
   localparam int NPOS = NB + 2 * ND;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   led_scan_mux_if #(.NUM_BANKS(NB), .NUM_DIGITS(ND)) bus ();

   led_scan_mux #(
      .NUM_BANKS(NB), .NUM_DIGITS(ND), .DWELL_CLKS(DW), .BLINK_FRAMES(BF)
   ) dut (
      .iClk(clk), .iRst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Segment patterns gfedcba, active low, for codes 0..16.
   logic [6:0] seg_tbl [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h3F};

   function automatic logic [7:0] exp_digit(input logic [4:0] code, input logic dp);
      logic [6:0] s;
      s = (code <= 5'd16) ? seg_tbl[code] : 7'h7F;
      return {~dp, s};
   endfunction

   // Reference model: current slot index (-1 = idle), cycles left in slot, frames wrapped since reset.
   int m_pos = -1, m_left = 0, m_wraps = 0;
   logic [7:0]    e_led  = 8'h00;
   logic [NB-1:0] e_bsel = '0;
   logic [ND-1:0] e_dsel = '1;
   logic          e_fs   = 1'b0;

   function automatic bit slot_enabled(input int p);
      if (p < NB) return bus.iBankEn[p];
      return bus.iDigitEn[(p - NB) / 2];
   endfunction

   task automatic model_reset();
      m_pos = -1; m_left = 0; m_wraps = 0;
      e_led = 8'h00; e_bsel = '0; e_dsel = '1; e_fs = 1'b0;
   endtask

   task automatic model_step();
      int np, d;
      e_fs = 1'b0;
      if (m_pos < 0) begin
         np = -1;
         for (int p = NPOS - 1; p >= 0; p--) if (slot_enabled(p)) np = p;
         if (np >= 0) begin
            m_pos = np; m_left = DW; e_fs = 1'b1;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            np = -1;
            for (int k = 1; k <= NPOS; k++)
               if (np < 0 && slot_enabled((m_pos + k) % NPOS)) np = (m_pos + k) % NPOS;
            if (np < 0) m_pos = -1;
            else begin
               if (np <= m_pos) begin m_wraps++; e_fs = 1'b1; end
               m_pos = np; m_left = DW;
            end
         end
      end
      e_led = 8'h00; e_bsel = '0; e_dsel = '1;
      if (m_pos >= 0) begin
         if (m_pos < NB) begin
            e_bsel[m_pos] = bus.iBankEn[m_pos];
            e_led = (bus.iBlinkMask[m_pos] && ((m_wraps / BF) % 2 == 1)) ? 8'h00 : bus.iBankData[8*m_pos +: 8];
         end else if ((m_pos - NB) % 2 == 0) begin
            d = (m_pos - NB) / 2;
            e_dsel[d] = ~bus.iDigitEn[d];
            e_led = exp_digit(bus.iDigitVal[5*d +: 5], bus.iDigitDp[d]);
         end else begin
            e_led = 8'hFF;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
         #1;
         check_eq("sb_led",  32'(bus.oLedData),    32'(e_led));
         check_eq("sb_bsel", 32'(bus.oBankSel),    32'(e_bsel));
         check_eq("sb_dsel", 32'(bus.oDigitSel_N), 32'(e_dsel));
         check_eq("sb_fs",   32'(bus.oFrameStart), 32'(e_fs));
         check_eq("onehot",  32'(($countones(bus.oBankSel) + $countones(~bus.oDigitSel_N)) <= 1), 32'd1);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_defaults();
      for (int b = 0; b < NB; b++) bus.iBankData[8*b +: 8] = 8'(17 * (b + 1));
      bus.iBankEn    = '1;
      bus.iBlinkMask = '0;
      bus.iDigitVal  = {5'd16, 5'd10};
      bus.iDigitDp   = 2'b01;
      bus.iDigitEn   = '1;
   endtask

   initial begin
      int fs_cnt, cnt0;
      logic [NB-1:0] xb;
      logic [ND-1:0] xd;
      logic [7:0]    xl;
      logic [7:0]    blink_exp;

      set_defaults();
      tick();
      check_eq("rst_led",  32'(bus.oLedData),    32'h00);
      check_eq("rst_bsel", 32'(bus.oBankSel),    32'h00);
      check_eq("rst_dsel", 32'(bus.oDigitSel_N), 32'h3);
      check_eq("rst_fs",   32'(bus.oFrameStart), 32'h0);
      tick();
      rst_n = 1'b1;

      // Full scan, every slot enabled.
      fs_cnt = 0;
      for (int k = 0; k <= 40; k++) begin
         tick();
         if (k == 0 || k == 40) check_eq("frame_start", 32'(bus.oFrameStart), 32'd1);
         else fs_cnt += int'(bus.oFrameStart);
         if (k % 4 == 1 && k < 40) begin
            xb = '0; xd = 2'b11; xl = 8'hFF;
            if (k / 4 < NB) begin xb[k/4] = 1'b1; xl = 8'(17 * (k / 4 + 1)); end
            else if (k / 4 == 6) begin xd = 2'b10; xl = 8'h08; end
            else if (k / 4 == 8) begin xd = 2'b01; xl = 8'hBF; end
            check_eq($sformatf("full_bsel_s%0d", k / 4), 32'(bus.oBankSel),    32'(xb));
            check_eq($sformatf("full_dsel_s%0d", k / 4), 32'(bus.oDigitSel_N), 32'(xd));
            check_eq($sformatf("full_led_s%0d",  k / 4), 32'(bus.oLedData),    32'(xl));
         end
      end
      check_eq("full_fs_midframe", 32'(fs_cnt), 32'd0);

      // Reset in the middle of the second digit's slot.
      repeat (33) tick();
      check_eq("mid_dig1_dsel", 32'(bus.oDigitSel_N), 32'h1);
      rst_n = 1'b0;
      #1;
      check_eq("arst_led",  32'(bus.oLedData),    32'h00);
      check_eq("arst_bsel", 32'(bus.oBankSel),    32'h00);
      check_eq("arst_dsel", 32'(bus.oDigitSel_N), 32'h3);
      check_eq("arst_fs",   32'(bus.oFrameStart), 32'h0);
      bus.iBlinkMask = 6'b000010;
      bus.iBankData[15:8] = 8'hAA;
      tick();
      tick();
      rst_n = 1'b1;

      // Restart from reset, then blink of bank 1 over six frames.
      cnt0 = 0;
      for (int k = 0; k < 240; k++) begin
         tick();
         if (k < 6 && bus.oBankSel == 6'b000001) cnt0++;
         if (k == 0) check_eq("rel_fs", 32'(bus.oFrameStart), 32'd1);
         if (k == 4) check_eq("rel_bank1_after4", 32'(bus.oBankSel), 32'h02);
         if (k % 40 == 5) begin
            blink_exp = ((k / 40) % 4 < 2) ? 8'hAA : 8'h00;
            check_eq($sformatf("blink_led_f%0d", k / 40), 32'(bus.oLedData), 32'(blink_exp));
            check_eq($sformatf("blink_sel_f%0d", k / 40), 32'(bus.oBankSel), 32'h02);
         end
      end
      check_eq("rel_bank0_cycles", 32'(cnt0), 32'd4);

      // Two banks only, then all disabled, then bank 4 alone.
      rst_n = 1'b0;
      bus.iBlinkMask = '0;
      bus.iBankEn    = 6'b000101;
      bus.iDigitEn   = '0;
      tick();
      tick();
      rst_n = 1'b1;
      fs_cnt = 0;
      for (int k = 0; k < 24; k++) begin
         tick();
         case (k)
            0, 8: begin
               check_eq("alt_fs",     32'(bus.oFrameStart), 32'd1);
               check_eq("alt_bank0",  32'(bus.oBankSel),    32'h01);
            end
            4: begin
               check_eq("alt_bank2",  32'(bus.oBankSel),    32'h04);
               check_eq("alt_nofs",   32'(bus.oFrameStart), 32'd0);
            end
            9: bus.iBankEn = '0;
            12: begin
               check_eq("idle_bsel",  32'(bus.oBankSel),    32'h00);
               check_eq("idle_dsel",  32'(bus.oDigitSel_N), 32'h3);
               check_eq("idle_led",   32'(bus.oLedData),    32'h00);
            end
            23: begin
               check_eq("reen_fs",    32'(bus.oFrameStart), 32'd1);
               check_eq("reen_bank4", 32'(bus.oBankSel),    32'h10);
            end
            default: ;
         endcase
         if (k >= 13 && k <= 22) fs_cnt += int'(bus.oFrameStart);
         if (k == 22) begin
            check_eq("idle_no_fs", 32'(fs_cnt), 32'd0);
            bus.iBankEn = 6'b010000;
         end
      end

      // Randomized enables and data; the scoreboard checks every cycle.
      for (int c = 0; c < 10000; c++) begin
         tick();
         if ($urandom_range(0, 15) == 0) begin
            bus.iBankEn  = 6'($urandom);
            bus.iDigitEn = 2'($urandom);
         end
         if ($urandom_range(0, 7) == 0) begin
            bus.iBankData  = 48'({$urandom, $urandom});
            bus.iBlinkMask = 6'($urandom);
            bus.iDigitVal  = 10'($urandom);
            bus.iDigitDp   = 2'($urandom);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
